// File: rtl/dh_pkg.sv
// Shared types and defaults for the DH modular-exponentiation scheduler.
// Owner encoding, FSM states and default operand widths.
package dh_pkg;

    localparam int DH_W  = 32;
    localparam int DH_EW = 32;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RB_GO,
        ST_RB_WT,
        ST_SQ_GO,
        ST_SQ_WT,
        ST_MU_GO,
        ST_MU_WT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mod_reduce.sv
// Restoring shift-subtract reducer: r = a mod m for a 2W-bit a.
// One quotient bit per cycle; done pulses exactly 2W cycles after start.
module mod_reduce
    import dh_pkg::*;
#(
    parameter int W = DH_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] a,
    input  logic [W-1:0]   m,
    output logic [W-1:0]   r,
    output logic           done
);

    localparam int CW = $clog2(2 * W) + 1;

    logic [2*W-1:0] sh;
    logic [CW-1:0]  cnt;
    logic           run;
    logic [W-1:0]   src_rem;
    logic           src_bit;
    logic [W:0]     trial;
    logic [W-1:0]   nxt;

    // One restoring step; the start cycle already consumes the first bit of a.
    always_comb begin
        src_rem = start ? '0 : r;
        src_bit = start ? a[2*W-1] : sh[2*W-1];
        trial   = {src_rem, src_bit};
        nxt     = trial[W-1:0];
        if (trial >= {1'b0, m})
            nxt = W'(trial - {1'b0, m});
    end

    // Partial remainder, dividend shifter and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r    <= '0;
            sh   <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r   <= nxt;
                sh  <= a << 1;
                cnt <= CW'(2 * W - 1);
                run <= 1'b1;
            end else if (run) begin
                r   <= nxt;
                sh  <= sh << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dh_exp_scheduler.sv
// Round-robin share of one modexp engine between DH parties A and B.
// Left-to-right square-and-multiply over a single shared mod_reduce.
module dh_exp_scheduler
    import dh_pkg::*;
#(
    parameter int W  = DH_W,
    parameter int EW = DH_EW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic [W-1:0]  base_a,
    input  logic [EW-1:0] exp_a,
    input  logic          req_b,
    input  logic [W-1:0]  base_b,
    input  logic [EW-1:0] exp_b,
    input  logic [W-1:0]  p,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          busy,
    output logic [W-1:0]  result,
    output logic          res_owner,
    output logic          res_valid,
    output logic          err
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    state_t         state;
    logic [W-1:0]   acc;
    logic [W-1:0]   bas;
    logic [W-1:0]   m;
    logic [EW-1:0]  e;
    logic [IW-1:0]  idx;
    logic           owner;
    logic           last_owner;
    logic           bad;
    logic           pick_b;
    logic           last_bit;
    logic           red_start;
    logic           red_done;
    logic [2*W-1:0] red_a;
    logic [W-1:0]   red_r;
    logic [2*W-1:0] acc_w;
    logic [2*W-1:0] bas_w;

    assign pick_b   = req_b && (!req_a || last_owner == OWN_A);
    assign last_bit = (idx == '0);
    assign acc_w    = {{W{1'b0}}, acc};
    assign bas_w    = {{W{1'b0}}, bas};

    // Reducer operand and start strobe follow the *_GO states.
    always_comb begin
        red_start = 1'b0;
        red_a     = '0;
        if (state == ST_RB_GO) begin
            red_start = 1'b1;
            red_a     = bas_w;
        end else if (state == ST_SQ_GO) begin
            red_start = 1'b1;
            red_a     = acc_w * acc_w;
        end else if (state == ST_MU_GO) begin
            red_start = 1'b1;
            red_a     = acc_w * bas_w;
        end
    end

    mod_reduce #(.W(W)) u_red (
        .clk   (clk),
        .rst   (rst),
        .start (red_start),
        .a     (red_a),
        .m     (m),
        .r     (red_r),
        .done  (red_done)
    );

    // Arbiter, sequencer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            bas        <= '0;
            m          <= '0;
            e          <= '0;
            idx        <= '0;
            owner      <= OWN_A;
            last_owner <= OWN_B;
            bad        <= 1'b0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
            res_owner  <= 1'b0;
            res_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (!res_valid && (req_a || req_b)) begin
                        state      <= ST_LOAD;
                        busy       <= 1'b1;
                        gnt_a      <= !pick_b;
                        gnt_b      <= pick_b;
                        owner      <= pick_b ? OWN_B : OWN_A;
                        last_owner <= pick_b ? OWN_B : OWN_A;
                        bas        <= pick_b ? base_b : base_a;
                        e          <= pick_b ? exp_b : exp_a;
                        m          <= p;
                    end
                end
                ST_LOAD: begin
                    acc   <= W'(1);
                    idx   <= IW'(EW - 1);
                    bad   <= (m < W'(2));
                    state <= (m < W'(2)) ? ST_DONE : ST_RB_GO;
                end
                ST_RB_GO: state <= ST_RB_WT;
                ST_RB_WT: begin
                    if (red_done) begin
                        bas   <= red_r;
                        state <= ST_SQ_GO;
                    end
                end
                ST_SQ_GO: state <= ST_SQ_WT;
                ST_SQ_WT: begin
                    if (red_done) begin
                        acc <= red_r;
                        if (e[idx]) begin
                            state <= ST_MU_GO;
                        end else if (last_bit) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx - IW'(1);
                            state <= ST_SQ_GO;
                        end
                    end
                end
                ST_MU_GO: state <= ST_MU_WT;
                ST_MU_WT: begin
                    if (red_done) begin
                        acc <= red_r;
                        if (last_bit) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx - IW'(1);
                            state <= ST_SQ_GO;
                        end
                    end
                end
                ST_DONE: begin
                    res_valid <= 1'b1;
                    err       <= bad;
                    result    <= bad ? '0 : acc;
                    res_owner <= owner;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dh_exp_scheduler.sv
// Bench for dh_exp_scheduler: directed cases plus randomized traffic,
// all checked against a cycle-level behavioural model.
module tb_dh_exp_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b;
    logic [31:0] base_a, exp_a, base_b, exp_b, p;
    logic        gnt_a, gnt_b, busy, res_owner, res_valid, err;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    dh_exp_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .base_a    (base_a),
        .exp_a     (exp_a),
        .req_b     (req_b),
        .base_b    (base_b),
        .exp_b     (exp_b),
        .p         (p),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .busy      (busy),
        .result    (result),
        .res_owner (res_owner),
        .res_valid (res_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic no_event(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event expected one within bound", nm);
    endtask

    // Right-to-left modexp with wide arithmetic.
    function automatic logic [31:0] m_pow(input logic [31:0] b,
                                          input logic [31:0] e,
                                          input logic [31:0] pp);
        logic [63:0] r;
        logic [63:0] x;
        if (pp < 2) return 32'd0;
        r = 64'd1 % {32'd0, pp};
        x = {32'd0, b} % {32'd0, pp};
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % {32'd0, pp};
            x = (x * x) % {32'd0, pp};
        end
        return r[31:0];
    endfunction

    function automatic int m_lat(input logic [31:0] e, input logic [31:0] pp);
        if (pp < 2) return 2;
        return 2 + (1 + 32 + $countones(e)) * 65;
    endfunction

    // Model state.
    bit          m_pend = 0;
    int          m_due = 0;
    bit          m_last_b = 1;
    bit          m_own_b = 0;
    logic [31:0] m_res = 0;
    bit          m_err = 0;
    logic [31:0] m_hres = 0;
    bit          m_hown = 0;
    bit          p_elig = 0;
    bit          p_ra = 0, p_rb = 0;
    logic [31:0] p_ba = 0, p_ea = 0, p_bb = 0, p_eb = 0, p_p = 0;

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        bit eg_a, eg_b, exp_rv;
        logic [31:0] wb, we;
        if (!rst) begin
            chk("reset_outs",
                {26'd0, gnt_a, gnt_b, busy, res_valid, err, res_owner, result},
                64'd0);
            m_pend   = 0;
            m_last_b = 1;
            m_hres   = 0;
            m_hown   = 0;
            p_elig   = 0;
        end else begin
            eg_b = p_elig && p_rb && (!p_ra || !m_last_b);
            eg_a = p_elig && p_ra && !eg_b;
            chk("gnt_a", gnt_a, eg_a);
            chk("gnt_b", gnt_b, eg_b);
            if (eg_a || eg_b) begin
                wb       = eg_b ? p_bb : p_ba;
                we       = eg_b ? p_eb : p_ea;
                m_res    = m_pow(wb, we, p_p);
                m_err    = (p_p < 2);
                m_due    = cyc + m_lat(we, p_p);
                m_pend   = 1;
                m_last_b = eg_b;
                m_own_b  = eg_b;
            end
            exp_rv = m_pend && (cyc == m_due);
            chk("res_valid", res_valid, exp_rv);
            if (exp_rv) begin
                m_hres = m_res;
                m_hown = m_own_b;
            end
            chk("result", result, m_hres);
            chk("res_owner", res_owner, m_hown);
            chk("err", err, exp_rv && m_err);
            chk("busy", busy, m_pend);
            if (exp_rv) m_pend = 0;
            p_elig = !m_pend && !exp_rv;
        end
        p_ra = req_a;
        p_rb = req_b;
        p_ba = base_a;
        p_ea = exp_a;
        p_bb = base_b;
        p_eb = exp_b;
        p_p  = p;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (gnt_a || gnt_b) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int k = 0; k < 5000; k++) begin
            step();
            if (res_valid) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic serve(input bit pb, input logic [31:0] b,
                         input logic [31:0] e, input logic [31:0] pp,
                         output int lat, output logic [31:0] res,
                         output bit own, output bit er);
        bit ok;
        int g;
        lat = -1;
        res = 0;
        own = 0;
        er  = 0;
        if (pb) begin
            req_b = 1; base_b = b; exp_b = e;
        end else begin
            req_a = 1; base_a = b; exp_a = e;
        end
        p = pp;
        wait_gnt(ok);
        if (!ok) begin
            no_event("serve_gnt");
            req_a = 0; req_b = 0;
            return;
        end
        chk("serve_gnt_b", gnt_b, pb);
        g = cyc;
        req_a  = 0;
        req_b  = 0;
        base_a = $urandom;
        base_b = $urandom;
        exp_a  = $urandom;
        exp_b  = $urandom;
        p      = $urandom;
        wait_done(ok);
        if (!ok) begin
            no_event("serve_done");
            return;
        end
        lat = cyc - g;
        res = result;
        own = res_owner;
        er  = err;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          ra_cyc;
        logic [31:0] res;
        bit          own, er, ok, ga, ra, rb;
        rst = 1'b0;
        req_a = 0; req_b = 0;
        base_a = 0; exp_a = 0; base_b = 0; exp_b = 0; p = 0;
        reset_dut();

        chk("model_5_6_23", m_pow(32'd5, 32'd6, 32'd23), 64'd8);
        chk("model_2_10_1000", m_pow(32'd2, 32'd10, 32'd1000), 64'd24);
        chk("model_big", m_pow(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB), 64'd16);
        chk("model_lat", m_lat(32'd6, 32'd23), 64'd2277);

        // Test 1
        serve(0, 32'd5, 32'd6, 32'd23, lat, res, own, er);
        chk("t1_result", res, 64'd8);
        chk("t1_owner", own, 64'd0);
        chk("t1_err", er, 64'd0);
        chk("t1_latency", lat, 64'd2277);
        repeat (2) step();

        // Test 2
        serve(1, 32'd2, 32'd10, 32'd1000, lat, res, own, er);
        chk("t2_result", res, 64'd24);
        chk("t2_owner", own, 64'd1);
        step();
        chk("t2_busy_low", busy, 64'd0);
        repeat (2) step();

        // Test 3: simultaneous requests out of reset
        reset_dut();
        req_a = 1; base_a = 5; exp_a = 6;
        req_b = 1; base_b = 2; exp_b = 10;
        p = 23;
        wait_gnt(ok);
        chk("t3_first_a", {gnt_a, gnt_b}, 64'd2);
        req_a = 0;
        p = 1000;
        wait_done(ok);
        if (!ok) no_event("t3_a_done");
        ra_cyc = cyc;
        chk("t3_a_result", result, 64'd8);
        chk("t3_a_owner", res_owner, 64'd0);
        wait_gnt(ok);
        if (!ok) no_event("t3_b_gnt");
        chk("t3_gnt_b", gnt_b, 64'd1);
        chk("t3_gnt_gap", cyc - ra_cyc, 64'd2);
        req_b = 0;
        wait_done(ok);
        if (!ok) no_event("t3_b_done");
        chk("t3_b_result", result, 64'd24);
        chk("t3_b_owner", res_owner, 64'd1);
        repeat (2) step();

        // Test 4
        serve(0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB, lat, res, own, er);
        chk("t4_big", res, 64'd16);
        chk("t4_big_lat", lat, 64'd2212);
        serve(1, 32'd12345, 32'd0, 32'd7, lat, res, own, er);
        chk("t4_e0", res, 64'd1);
        chk("t4_e0_lat", lat, 64'd2147);

        // Test 5
        serve(0, 32'd5, 32'd3, 32'd1, lat, res, own, er);
        chk("t5_p1_err", er, 64'd1);
        chk("t5_p1_res", res, 64'd0);
        chk("t5_p1_lat", lat, 64'd2);
        step();
        serve(1, 32'd9, 32'd9, 32'd0, lat, res, own, er);
        chk("t5_p0_err", er, 64'd1);
        chk("t5_p0_res", res, 64'd0);
        chk("t5_p0_lat", lat, 64'd2);
        repeat (2) step();

        // Test 6: reset in the middle of a squaring
        reset_dut();
        req_b = 1; base_b = 3; exp_b = 5; p = 101;
        wait_gnt(ok);
        chk("t6_gnt_b", gnt_b, 64'd1);
        repeat (80) step();
        #1 rst = 1'b0;
        #1;
        chk("t6_abort",
            {gnt_a, gnt_b, busy, res_valid, err, res_owner, result}, 64'd0);
        repeat (3) step();
        rst = 1'b1;
        wait_gnt(ok);
        if (!ok) no_event("t6_regnt");
        ra_cyc = cyc;
        chk("t6_regnt_b", gnt_b, 64'd1);
        req_b = 0;
        wait_done(ok);
        if (!ok) no_event("t6_done");
        chk("t6_result", result, 64'd41);
        chk("t6_owner", res_owner, 64'd1);
        chk("t6_latency", cyc - ra_cyc, 64'd2277);
        repeat (2) step();

        // Randomized traffic
        for (int it = 0; it < 8; it++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1;
            base_a = $urandom; exp_a = $urandom;
            base_b = $urandom; exp_b = $urandom;
            if ($urandom_range(0, 3) == 0) p = $urandom_range(0, 3);
            else p = $urandom;
            req_a = ra;
            req_b = rb;
            wait_gnt(ok);
            if (!ok) begin
                no_event("rnd_gnt");
                req_a = 0; req_b = 0;
                continue;
            end
            ga = gnt_a;
            if (ga) req_a = 0;
            else req_b = 0;
            ok = 0;
            for (int k = 0; k < 5000; k++) begin
                step();
                if (res_valid) begin
                    ok = 1;
                    break;
                end
                if (ga) req_b = 1'($urandom_range(0, 1));
                else req_a = 1'($urandom_range(0, 1));
                base_a = $urandom;
                base_b = $urandom;
                p = $urandom;
            end
            if (!ok) no_event("rnd_done");
            req_a = 0;
            req_b = 0;
            repeat ($urandom_range(1, 3)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
